sb_rmw_ctrl: RTL

Sequencer for byte stores (sb) to a word-wide data memory. It accepts one byte-store request at a time and reads the containing word. It merges the byte through an internal wordmod instance (byte lane = addr[1:0]) and writes the merged word back. The block sits between the datapath's store path and the single-port synchronous data memory, and owns the memory port for the duration of each read-modify-write (RMW).

---
 rtl/sb_rmw_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/sb_rmw_ctrl.sv
// Byte-store read-modify-write sequencer: reads the containing word, merges one byte lane
// and writes the word back, owning the single-port memory for the whole sequence.
module sb_rmw_ctrl #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [7:0]       req_byte,
    output logic [31:0]      mem_addr,
    output logic             mem_rd_en,
    input  logic [31:0]      mem_rdata,
    output logic             mem_wr_en,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] store_cnt
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int unsigned     LAT_W    = 2;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    logic [2:0]       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [31:0]      addr_q;
    logic [7:0]       byte_q;
    logic [31:0]      orig_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             rdata_take;

    // Byte-lane merge: only the lane selected by the low address bits is replaced.
    function automatic logic [31:0] wordmod(input logic [1:0]  lane,
                                            input logic [31:0] word,
                                            input logic [7:0]  byte_in);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = byte_in;
            2'd1:    res[15:8]  = byte_in;
            2'd2:    res[23:16] = byte_in;
            default: res[31:24] = byte_in;
        endcase
        return res;
    endfunction

    assign accept     = req_valid && req_ready;
    assign rdata_take = (state_q == WAIT) && (lat_q == '0);

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ: begin
                lat_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) state_d = WRITE;
                else             lat_d   = lat_q - 1'b1;
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            addr_q  <= '0;
            byte_q  <= '0;
            orig_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (accept) begin
                addr_q <= req_addr;
                byte_q <= req_byte;
            end
            // Read data is only looked at in the last wait cycle, so X elsewhere is harmless.
            if (rdata_take) orig_q <= mem_rdata;
            if (state_q == DONE) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_rd_en = (state_q == READ);
    assign mem_wr_en = (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign mem_addr  = (state_q == IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
    assign mem_wdata = (state_q == WRITE) ? wordmod(addr_q[1:0], orig_q, byte_q) : 32'd0;
    assign store_cnt = cnt_q;

endmodule
